// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the execute stage.
//   - ALU function codes driven on the ALU F input
//   - state encoding of the multiply sequencer
package alu_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/Alu32bit.sv
// Shared 32-bit ALU (combinational), instantiated by the parent beside the
// multiply sequencer.
//   a, b  : operands
//   f     : function code (f[2] inverts b and injects carry-in for SUB/SLT)
//   r     : result
//   cout  : carry-out of the adder (true 33rd sum bit)
module Alu32bit
   import alu_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  f,
   output logic [31:0] r,
   output logic        cout
);

   logic [31:0] bb;
   logic [32:0] sum;

   always_comb begin
      bb   = f[2] ? ~b : b;
      sum  = {1'b0, a} + {1'b0, bb} + {32'd0, f[2]};
      cout = sum[32];
      case (f[1:0])
         2'b00:   r = a & bb;
         2'b01:   r = a | bb;
         2'b10:   r = sum[31:0];
         default: r = {31'd0, sum[31]};
      endcase
   end

endmodule

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-add multiplier that borrows the shared ALU for
// one add per cycle while busy.
//   clk, reset        : clock, synchronous active-high reset
//   start, in_ready   : request / accept handshake (accept when both high)
//   op_a, op_b        : multiplicand / multiplier, sampled on accept
//   busy, done        : busy in RUN and DONE; done pulses one cycle
//   prod_hi, prod_lo  : 2*WIDTH-bit product, held until the next accept
//   alu_a/alu_b/alu_f : ALU operand/function drive (zero operands outside RUN)
//   alu_r, alu_cout   : ALU result and carry-out, same cycle
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter logic [2:0]  ADD_OP = ALU_ADD
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_f,
   input  logic [WIDTH-1:0] alu_r,
   input  logic             alu_cout
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mul_state_t       state, nstate;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         mcand   <= '0;
         prod_hi <= '0;
         prod_lo <= '0;
      end else begin
         state <= nstate;
         case (state)
            IDLE: begin
               if (start) begin
                  mcand   <= op_a;
                  prod_hi <= '0;
                  prod_lo <= op_b;
                  cnt     <= '0;
               end
            end
            RUN: begin
               // Sum (with carry as its top bit) shifts right by one; the bit
               // falling out of the sum enters the top of the multiplier
               // register as the multiplier bits are consumed.
               prod_hi <= {alu_cout, alu_r[WIDTH-1:1]};
               prod_lo <= {alu_r[0], prod_lo[WIDTH-1:1]};
               cnt     <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      nstate   = state;
      alu_a    = '0;
      alu_b    = '0;
      alu_f    = ADD_OP;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (start) nstate = RUN;
         end
         RUN: begin
            busy  = 1'b1;
            alu_a = prod_hi;
            alu_b = prod_lo[0] ? mcand : '0;
            if (cnt == LAST) nstate = DONE;
         end
         DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

endmodule
